mux_8to1_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 8:1 select-path multiplexer (`mux_8to1`). Eight requesters compete for the single output lane; the arbiter grants one at a time and drives the mux `sel` bus. It holds the grant for a burst, handshakes accepted beats with the downstream consumer, and forces rotation after a programmable beat limit so no requester starves.

---
 rtl/mux_8to1_arbiter_pkg.sv | 20 ++
 rtl/rr_pick_8.sv | 31 +++
 rtl/mux_8to1_arbiter.sv | 85 ++++++++
 tb/tb_mux_8to1_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_8to1_arbiter_pkg.sv
// Shared definitions for the 8:1 mux round-robin arbiter.
//   ARB_N / ARB_SEL_W : requester count and select-bus width
//   arb_state_e       : two-state controller encoding
//   arb_onehot        : index -> one-hot grant vector
package mux_8to1_arbiter_pkg;

   localparam int unsigned ARB_N     = 8;
   localparam int unsigned ARB_SEL_W = 3;
   localparam logic [7:0]  BEAT_MAX  = 8'hFF;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

   function automatic logic [ARB_N-1:0] arb_onehot(input logic [ARB_SEL_W-1:0] idx);
      return {{(ARB_N-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/rr_pick_8.sv
// Rotating priority encoder: finds the first set request scanning upward from
// the pointer, wrapping 7 -> 0.
//   i_req [7:0] : request vector
//   i_ptr [2:0] : highest-priority index
//   o_any       : at least one request set
//   o_idx [2:0] : winning index (0 when o_any is low)
module rr_pick_8
   import mux_8to1_arbiter_pkg::*;
(
   input  logic [ARB_N-1:0]     i_req,
   input  logic [ARB_SEL_W-1:0] i_ptr,
   output logic                 o_any,
   output logic [ARB_SEL_W-1:0] o_idx
);

   logic w_found;

   always_comb begin
      o_any   = |i_req;
      o_idx   = '0;
      w_found = 1'b0;
      for (int i = 0; i < ARB_N; i++) begin
         // 3-bit addition wraps naturally past index 7
         if (!w_found && i_req[i_ptr + ARB_SEL_W'(i)]) begin
            o_idx   = i_ptr + ARB_SEL_W'(i);
            w_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_8to1_arbiter.sv
// Round-robin arbiter and sequencer driving the select bus of a shared 8:1 mux.
// Grants one requester at a time, counts accepted beats and forces rotation
// after MAX_HOLD beats (0 = unlimited).
//   i_clk, i_rst_n   : clock, async active-low reset
//   i_req [7:0]      : per-requester request, held for the whole burst
//   i_out_ready      : downstream accepts the current beat
//   o_sel [2:0]      : mux select (owner index; keeps last owner while idle)
//   o_gnt [7:0]      : one-hot grant, zero when idle
//   o_out_valid      : current mux output is a valid beat from the owner
//   o_beat_cnt [7:0] : beats accepted in the current grant (saturating)
module mux_8to1_arbiter
   import mux_8to1_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [ARB_N-1:0]     i_req,
   input  logic                 i_out_ready,
   output logic [ARB_SEL_W-1:0] o_sel,
   output logic [ARB_N-1:0]     o_gnt,
   output logic                 o_out_valid,
   output logic [7:0]           o_beat_cnt
);

   localparam bit         HOLD_EN  = (MAX_HOLD != 0);
   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

   arb_state_e           r_state;
   logic [ARB_N-1:0]     r_gnt;
   logic [ARB_SEL_W-1:0] r_sel;
   logic [ARB_SEL_W-1:0] r_ptr;
   logic [7:0]           r_beat_cnt;

   logic                 w_any;
   logic [ARB_SEL_W-1:0] w_idx;
   logic                 w_accept;
   logic [7:0]           w_cnt_next;
   logic                 w_release;

   rr_pick_8 u_pick (
      .i_req (i_req),
      .i_ptr (r_ptr),
      .o_any (w_any),
      .o_idx (w_idx)
   );

   // Only output not taken straight from a register: follows the owner's request
   assign o_out_valid = (r_state == ARB_GRANT) & i_req[r_sel];
   assign w_accept    = o_out_valid & i_out_ready;
   assign w_cnt_next  = (r_beat_cnt == BEAT_MAX) ? BEAT_MAX : r_beat_cnt + 8'd1;
   // Owner drop and limit-reaching beat in the same cycle yield a single release
   assign w_release   = ~i_req[r_sel] | (HOLD_EN & w_accept & (w_cnt_next == HOLD_LIM));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ARB_IDLE;
         r_gnt      <= '0;
         r_sel      <= '0;
         r_ptr      <= '0;
         r_beat_cnt <= '0;
      end else if (r_state == ARB_IDLE) begin
         if (w_any) begin
            r_state    <= ARB_GRANT;
            r_gnt      <= arb_onehot(w_idx);
            r_sel      <= w_idx;
            r_ptr      <= w_idx + 3'd1;
            r_beat_cnt <= '0;
         end
      end else begin
         if (w_release) begin
            r_state    <= ARB_IDLE;
            r_gnt      <= '0;
            r_beat_cnt <= '0;
         end else if (w_accept) begin
            r_beat_cnt <= w_cnt_next;
         end
      end
   end

   assign o_gnt      = r_gnt;
   assign o_sel      = r_sel;
   assign o_beat_cnt = r_beat_cnt;

endmodule

// File: tb/tb_mux_8to1_arbiter.sv
// Bench for mux_8to1_arbiter: a MAX_HOLD=2 instance and an unlimited instance,
// checked by directed tables, hand sequences and a cycle-level reference model.
module tb_mux_8to1_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] req0, req1;
   logic       rdy0, rdy1;
   logic [2:0] sel0, sel1;
   logic [7:0] gnt0, gnt1;
   logic       vld0, vld1;
   logic [7:0] cnt0, cnt1;

   int n_pass  = 0;
   int n_total = 0;

   mux_8to1_arbiter #(.MAX_HOLD(2)) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req       (req0),
      .i_out_ready (rdy0),
      .o_sel       (sel0),
      .o_gnt       (gnt0),
      .o_out_valid (vld0),
      .o_beat_cnt  (cnt0)
   );

   mux_8to1_arbiter #(.MAX_HOLD(0)) u_dut_unl (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req       (req1),
      .i_out_ready (rdy1),
      .o_sel       (sel1),
      .o_gnt       (gnt1),
      .o_out_valid (vld1),
      .o_beat_cnt  (cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: owner index (-1 when idle), last select, rotate pointer, beats
   int m_owner[2];
   int m_sel[2];
   int m_ptr[2];
   int m_cnt[2];
   int m_hold[2];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
   endtask

   function automatic int pick(input logic [7:0] r, input int p);
      for (int j = 0; j < 8; j++) if (r[(p + j) % 8]) return (p + j) % 8;
      return -1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_owner[d] = -1;
         m_sel[d]   = 0;
         m_ptr[d]   = 0;
         m_cnt[d]   = 0;
      end
   endtask

   task automatic model_check();
      for (int d = 0; d < 2; d++) begin
         logic [7:0] eg;
         logic [7:0] r;
         logic       ev;
         r  = (d == 0) ? req0 : req1;
         eg = '0;
         ev = 1'b0;
         if (m_owner[d] >= 0) begin
            eg[m_owner[d]] = 1'b1;
            ev = r[m_owner[d]];
         end
         check($sformatf("model gnt%0d", d), (d == 0) ? gnt0 : gnt1, eg);
         check($sformatf("model sel%0d", d), (d == 0) ? sel0 : sel1, m_sel[d]);
         check($sformatf("model vld%0d", d), (d == 0) ? vld0 : vld1, ev);
         check($sformatf("model cnt%0d", d), (d == 0) ? cnt0 : cnt1, m_cnt[d]);
      end
   endtask

   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         logic [7:0] r;
         logic       rd;
         int         w;
         r  = (d == 0) ? req0 : req1;
         rd = (d == 0) ? rdy0 : rdy1;
         if (m_owner[d] < 0) begin
            w = pick(r, m_ptr[d]);
            if (w >= 0) begin
               m_owner[d] = w;
               m_sel[d]   = w;
               m_ptr[d]   = (w + 1) % 8;
               m_cnt[d]   = 0;
            end
         end else if (!r[m_owner[d]]) begin
            m_owner[d] = -1;
            m_cnt[d]   = 0;
         end else if (rd) begin
            if (m_cnt[d] < 255) m_cnt[d]++;
            if (m_hold[d] != 0 && m_cnt[d] == m_hold[d]) begin
               m_owner[d] = -1;
               m_cnt[d]   = 0;
            end
         end
      end
   endtask

   task automatic at_neg();
      @(negedge clk);
      model_check();
   endtask

   task automatic finish_cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      at_neg();
      finish_cycle();
   endtask

   typedef struct {
      logic [7:0] req;
      logic       rdy;
      logic [7:0] gnt;
      logic [2:0] sel;
      logic       vld;
      logic [7:0] cnt;
   } vec_t;

   vec_t tbl[20];

   initial begin
      // Directed sequence for the MAX_HOLD=2 instance, starting from reset
      tbl[0]  = '{8'h10, 1'b0, 8'h00, 3'd0, 1'b0, 8'd0};
      tbl[1]  = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 8'd0};
      tbl[2]  = '{8'h00, 1'b0, 8'h10, 3'd4, 1'b0, 8'd0};
      tbl[3]  = '{8'h00, 1'b0, 8'h00, 3'd4, 1'b0, 8'd0};
      tbl[4]  = '{8'h30, 1'b0, 8'h00, 3'd4, 1'b0, 8'd0};
      tbl[5]  = '{8'h30, 1'b1, 8'h20, 3'd5, 1'b1, 8'd0};
      tbl[6]  = '{8'h30, 1'b1, 8'h20, 3'd5, 1'b1, 8'd1};
      tbl[7]  = '{8'h30, 1'b1, 8'h00, 3'd5, 1'b0, 8'd0};
      tbl[8]  = '{8'h30, 1'b0, 8'h10, 3'd4, 1'b1, 8'd0};
      tbl[9]  = '{8'h00, 1'b0, 8'h10, 3'd4, 1'b0, 8'd0};
      tbl[10] = '{8'h20, 1'b0, 8'h00, 3'd4, 1'b0, 8'd0};
      tbl[11] = '{8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 8'd0};
      tbl[12] = '{8'h00, 1'b0, 8'h20, 3'd5, 1'b0, 8'd0};
      tbl[13] = '{8'h21, 1'b0, 8'h00, 3'd5, 1'b0, 8'd0};
      tbl[14] = '{8'h21, 1'b0, 8'h01, 3'd0, 1'b1, 8'd0};
      tbl[15] = '{8'h20, 1'b0, 8'h01, 3'd0, 1'b0, 8'd0};
      tbl[16] = '{8'h20, 1'b0, 8'h00, 3'd0, 1'b0, 8'd0};
      tbl[17] = '{8'h20, 1'b1, 8'h20, 3'd5, 1'b1, 8'd0};
      tbl[18] = '{8'h00, 1'b1, 8'h20, 3'd5, 1'b0, 8'd1};
      tbl[19] = '{8'h00, 1'b0, 8'h00, 3'd5, 1'b0, 8'd0};

      m_hold[0] = 2;
      m_hold[1] = 0;
      model_reset();
      rst_n = 1'b0;
      req0  = '0;
      req1  = '0;
      rdy0  = 1'b0;
      rdy1  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("reset gnt", gnt0, 8'h00);
      check("reset sel", sel0, 3'd0);
      check("reset vld", vld0, 1'b0);
      check("reset cnt", cnt0, 8'd0);
      finish_cycle();

      // Single requester, re-arbitration and wrap-around
      for (int i = 0; i < 20; i++) begin
         req0 = tbl[i].req;
         rdy0 = tbl[i].rdy;
         at_neg();
         check($sformatf("tbl[%0d] gnt", i), gnt0, tbl[i].gnt);
         check($sformatf("tbl[%0d] sel", i), sel0, tbl[i].sel);
         check($sformatf("tbl[%0d] vld", i), vld0, tbl[i].vld);
         check($sformatf("tbl[%0d] cnt", i), cnt0, tbl[i].cnt);
         finish_cycle();
      end

      // Backpressure: owner 3, one beat, then 5 stalled cycles, then the limit beat
      req0 = 8'h08;
      rdy0 = 1'b0;
      tick();
      rdy0 = 1'b1;
      tick();
      rdy0 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         at_neg();
         check("stall gnt", gnt0, 8'h08);
         check("stall cnt", cnt0, 8'd1);
         finish_cycle();
      end
      rdy0 = 1'b1;
      at_neg();
      check("resume vld", vld0, 1'b1);
      finish_cycle();
      at_neg();
      check("limit release gnt", gnt0, 8'h00);
      check("limit release cnt", cnt0, 8'd0);
      req0 = 8'h00;
      finish_cycle();

      // Unlimited hold: owner 0 kept through 300 beats, count saturates
      req1 = 8'h03;
      rdy1 = 1'b1;
      repeat (301) tick();
      at_neg();
      check("unl gnt", gnt1, 8'h01);
      check("unl sel", sel1, 3'd0);
      check("unl cnt", cnt1, 8'd255);
      req1 = 8'h00;
      finish_cycle();
      tick();

      // Async reset mid-grant (ptr is 4 here, so owner 6 wins)
      req0 = 8'hC0;
      rdy0 = 1'b0;
      tick();
      at_neg();
      check("pre-reset gnt", gnt0, 8'h40);
      rst_n = 1'b0;
      #1;
      check("async rst gnt", gnt0, 8'h00);
      check("async rst sel", sel0, 3'd0);
      check("async rst vld", vld0, 1'b0);
      check("async rst cnt", cnt0, 8'd0);
      model_reset();
      req0 = 8'hFF;
      rdy0 = 1'b1;
      @(posedge clk);
      #1;
      check("held rst gnt", gnt0, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      finish_cycle();

      // Rotation after reset: 0..7,0, two beats each plus one idle bubble
      for (int c = 0; c < 27; c++) begin
         logic [7:0] eg;
         eg = '0;
         if (c % 3 != 2) eg[(c / 3) % 8] = 1'b1;
         at_neg();
         check($sformatf("rot[%0d] gnt", c), gnt0, eg);
         check($sformatf("rot[%0d] cnt", c), cnt0, (c % 3 == 1) ? 8'd1 : 8'd0);
         finish_cycle();
      end

      // Random bursts against the model
      for (int c = 0; c < 400; c++) begin
         for (int b = 0; b < 8; b++) begin
            if ($urandom_range(7) == 0) req0[b] = ~req0[b];
            if ($urandom_range(7) == 0) req1[b] = ~req1[b];
         end
         rdy0 = ($urandom_range(3) != 0);
         rdy1 = ($urandom_range(3) != 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
